// File: rtl/hero_write_xact_buf.sv
// hero_write_xact_buf: transaction buffer for the hero write bus.
// Beats are stored as {last, wdat} in a DEPTH-entry FIFO. They are released
// downstream either cut-through or, in store-and-forward mode, only once a
// whole transaction (up to its DONE beat) is held. A store-and-forward
// transaction that cannot fit switches the buffer into OVERSIZE mode. In that
// mode the head is streamed cut-through until that transaction's DONE pops.
//
// Handshake: a beat moves on a cycle where the sender presents it and the
// receiver is ready. On the input side the sender presents it with
// in_cycle_type VALID/DONE and the receiver signals in_ready. On the output
// side the sender presents it with out_cycle_type != IDLE and the receiver
// signals out_ready. A presented beat is held unchanged until it is taken.
module hero_write_xact_buf #(
  parameter int DATA_WIDTH = 36,
  parameter int DEPTH      = 8,
  parameter bit STORE_FWD  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              in_cycle_type,
  input  logic [DATA_WIDTH-1:0]   in_wdat,
  output logic                    in_ready,
  output logic [1:0]              out_cycle_type,
  output logic [DATA_WIDTH-1:0]   out_wdat,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  xact_count,
  output logic                    proto_err,
  output logic                    oversize_err,
  output logic                    dbg_oversize
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] CT_IDLE    = 2'd0;
  localparam logic [1:0] CT_VALID   = 2'd1;
  localparam logic [1:0] CT_DONE    = 2'd2;
  localparam logic [1:0] CT_ILLEGAL = 2'd3;

  typedef enum logic {ST_NORMAL, ST_OVERSIZE} state_t;

  state_t                state;
  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  os_done_seen;

  logic full;
  logic empty;
  logic head_last;
  logic presentable;
  logic push;
  logic pop;
  logic push_done;
  logic pop_done;
  logic count_done;
  logic uncount_done;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign head_last = mem[rd_ptr][DATA_WIDTH];

  // Ready comes from registered occupancy only; held low during reset.
  assign in_ready = !full && !rst;

  assign presentable = !empty &&
                       (!STORE_FWD || (xact_count != '0) || (state == ST_OVERSIZE));

  assign push      = in_ready && ((in_cycle_type == CT_VALID) || (in_cycle_type == CT_DONE));
  assign pop       = presentable && out_ready;
  assign push_done = push && (in_cycle_type == CT_DONE);
  assign pop_done  = pop && head_last;

  // The DONE that closes the oversize transaction is never counted, so
  // popping it later must not decrement either.
  assign count_done   = push_done && !((state == ST_OVERSIZE) && !os_done_seen);
  assign uncount_done = pop_done && (state == ST_NORMAL);

  assign out_cycle_type = presentable ? (head_last ? CT_DONE : CT_VALID) : CT_IDLE;
  assign out_wdat       = presentable ? mem[rd_ptr][DATA_WIDTH-1:0] : '0;
  assign dbg_oversize   = (state == ST_OVERSIZE);

  // Storage array: written on every accepted beat, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {(in_cycle_type == CT_DONE), in_wdat};
    end
  end

  // Pointers, occupancy and complete-transaction count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      xact_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({count_done, uncount_done})
        2'b10:   xact_count <= xact_count + 1'b1;
        2'b01:   xact_count <= xact_count - 1'b1;
        default: xact_count <= xact_count;
      endcase
    end
  end

  // Sticky protocol error on any illegal beat type.
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (in_cycle_type == CT_ILLEGAL) begin
      proto_err <= 1'b1;
    end
  end

  // Oversize recovery FSM: entered when the FIFO fills with no complete
  // transaction inside, left when that transaction's DONE beat pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_NORMAL;
      os_done_seen <= 1'b0;
      oversize_err <= 1'b0;
    end else begin
      case (state)
        ST_NORMAL: begin
          os_done_seen <= 1'b0;
          if (STORE_FWD && full && (xact_count == '0)) begin
            state        <= ST_OVERSIZE;
            oversize_err <= 1'b1;
          end
        end
        ST_OVERSIZE: begin
          if (push_done) os_done_seen <= 1'b1;
          if (pop_done) begin
            state        <= ST_NORMAL;
            os_done_seen <= 1'b0;
          end
        end
        default: state <= ST_NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_hero_write_xact_buf.sv
// Directed bench for hero_write_xact_buf: a store-and-forward instance and a
// cut-through instance share one input stream.
module tb_hero_write_xact_buf;

  localparam int DW = 36;
  localparam int XW = 4;

  logic          clk;
  logic          rst;
  logic [1:0]    in_type;
  logic [DW-1:0] in_wdat;
  logic          out_ready;

  logic          s_in_ready, c_in_ready;
  logic [1:0]    s_out_type, c_out_type;
  logic [DW-1:0] s_out_wdat, c_out_wdat;
  logic [XW-1:0] s_xact, c_xact;
  logic          s_proto, c_proto, s_ovs_err, c_ovs_err, s_dbg, c_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] e;

  hero_write_xact_buf #(.DATA_WIDTH(DW), .DEPTH(8), .STORE_FWD(1'b1)) u_sf (
    .clk(clk), .rst(rst), .in_cycle_type(in_type), .in_wdat(in_wdat),
    .in_ready(s_in_ready), .out_cycle_type(s_out_type), .out_wdat(s_out_wdat),
    .out_ready(out_ready), .xact_count(s_xact), .proto_err(s_proto),
    .oversize_err(s_ovs_err), .dbg_oversize(s_dbg)
  );

  hero_write_xact_buf #(.DATA_WIDTH(DW), .DEPTH(8), .STORE_FWD(1'b0)) u_ct (
    .clk(clk), .rst(rst), .in_cycle_type(in_type), .in_wdat(in_wdat),
    .in_ready(c_in_ready), .out_cycle_type(c_out_type), .out_wdat(c_out_wdat),
    .out_ready(out_ready), .xact_count(c_xact), .proto_err(c_proto),
    .oversize_err(c_ovs_err), .dbg_oversize(c_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] t, input logic [DW-1:0] d);
    in_type = t;
    in_wdat = d;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] s_beat();
    return 64'({s_out_type, s_out_wdat});
  endfunction

  function automatic logic [63:0] c_beat();
    return 64'({c_out_type, c_out_wdat});
  endfunction

  function automatic logic [63:0] beat(input logic [1:0] t, input logic [DW-1:0] d);
    return 64'({t, d});
  endfunction

  initial begin
    int b;
    int cyc;
    int n_emit;
    bit seen_full;
    bit after_full;
    logic [1:0] t;

    rst = 1'b1;
    out_ready = 1'b1;
    drive(2'd0, '0);
    step();
    step();

    // Reset state
    check("rst_in_ready", s_in_ready, 0);
    check("rst_out_type", s_out_type, 0);
    check("rst_out_wdat", s_out_wdat, 0);
    check("rst_xact", s_xact, 0);
    check("rst_proto", s_proto, 0);
    check("rst_ovs", s_ovs_err, 0);
    check("rst_state", s_dbg, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", s_in_ready, 1);
    check("post_rst_out_type", s_out_type, 0);

    // Store-and-forward vs cut-through latency (cycles 1..7)
    drive(2'd1, 36'hA);
    check("c1_sf_idle", s_out_type, 0);
    check("c1_ct_idle_on_push", c_out_type, 0);
    step();
    drive(2'd1, 36'hB);
    check("c2_sf_idle", s_out_type, 0);
    check("c2_ct_a", c_beat(), beat(2'd1, 36'hA));
    step();
    drive(2'd2, 36'hC);
    check("c3_sf_idle", s_out_type, 0);
    check("c3_ct_b", c_beat(), beat(2'd1, 36'hB));
    step();
    drive(2'd0, '0);
    check("c4_sf_a", s_beat(), beat(2'd1, 36'hA));
    check("c4_sf_xact", s_xact, 1);
    check("c4_ct_c", c_beat(), beat(2'd2, 36'hC));
    step();
    check("c5_sf_b", s_beat(), beat(2'd1, 36'hB));
    check("c5_ct_idle", c_beat(), 0);
    step();
    check("c6_sf_c", s_beat(), beat(2'd2, 36'hC));
    step();
    check("c7_sf_idle", s_beat(), 0);
    check("c7_sf_xact", s_xact, 0);

    // Backpressure: two 4-beat transactions fill the FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      t = (i == 3 || i == 7) ? 2'd2 : 2'd1;
      drive(t, 36'(16 + i));
      if (i == 7) check("bp_ready_before_8th", s_in_ready, 1);
      exp_q.push_back({t, 36'(16 + i)});
      step();
    end
    drive(2'd0, '0);
    check("bp_full_ready", s_in_ready, 0);
    check("bp_full_xact", s_xact, 2);
    e = exp_q.pop_front();
    check("bp_head", s_beat(), 64'(e));
    out_ready = 1'b1;
    step();
    check("bp_ready_after_pop", s_in_ready, 1);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      e = exp_q.pop_front();
      check("bp_drain", s_beat(), 64'(e));
      if (cyc == 3) check("bp_xact_mid", s_xact, 1);
      step();
      cyc++;
    end
    check("bp_drain_idle", s_beat(), 0);
    check("bp_drain_xact", s_xact, 0);

    // Oversize: 12 VALID + DONE through the 8-entry store-and-forward buffer
    b = 0;
    cyc = 0;
    n_emit = 0;
    seen_full = 1'b0;
    after_full = 1'b0;
    exp_q.delete();
    while ((b < 13 || exp_q.size() != 0 || s_out_type != 2'd0) && cyc < 80) begin
      if (b < 13) drive((b == 12) ? 2'd2 : 2'd1, 36'(256 + b));
      else drive(2'd0, '0);
      if (s_out_type != 2'd0) begin
        if (exp_q.size() == 0) begin
          check("ovs_unexpected_beat", s_beat(), 0);
        end else begin
          e = exp_q.pop_front();
          check("ovs_beat", s_beat(), 64'(e));
          n_emit++;
        end
      end
      check("ovs_xact_zero", s_xact, 0);
      if (after_full) begin
        check("ovs_err_set", s_ovs_err, 1);
        check("ovs_state_oversize", s_dbg, 1);
        after_full = 1'b0;
      end
      if (!s_in_ready && !seen_full) begin
        seen_full = 1'b1;
        after_full = 1'b1;
        check("ovs_err_not_yet", s_ovs_err, 0);
      end
      if (s_in_ready && b < 13) begin
        exp_q.push_back({in_type, in_wdat});
        b++;
      end
      step();
      cyc++;
    end
    check("ovs_no_timeout", (cyc < 80), 1);
    check("ovs_saw_full", seen_full, 1);
    check("ovs_emitted", n_emit, 13);
    check("ovs_state_normal", s_dbg, 0);
    check("ovs_err_sticky", s_ovs_err, 1);
    check("ovs_end_xact", s_xact, 0);
    check("ct_no_ovs_err", c_ovs_err, 0);

    // Illegal beat type
    drive(2'd3, 36'h5);
    check("proto_before", s_proto, 0);
    step();
    drive(2'd0, '0);
    check("proto_set", s_proto, 1);
    check("proto_ct_set", c_proto, 1);
    check("proto_not_pushed", s_beat(), 0);
    step();
    step();
    check("proto_sticky", s_proto, 1);
    check("proto_no_out", s_beat(), 0);

    // Reset with a partial transaction stored
    for (int i = 0; i < 3; i++) begin
      drive(2'd1, 36'(32 + i));
      step();
    end
    drive(2'd0, '0);
    check("part_held", s_beat(), 0);
    rst = 1'b1;
    step();
    check("mid_rst_out", s_beat(), 0);
    check("mid_rst_xact", s_xact, 0);
    check("mid_rst_proto", s_proto, 0);
    check("mid_rst_ovs", s_ovs_err, 0);
    check("mid_rst_ready", s_in_ready, 0);
    rst = 1'b0;
    drive(2'd2, 36'h33);
    step();
    drive(2'd0, '0);
    check("after_rst_done", s_beat(), beat(2'd2, 36'h33));
    check("after_rst_xact", s_xact, 1);
    step();
    check("after_rst_idle", s_beat(), 0);
    check("after_rst_xact0", s_xact, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
